// File: rtl/picorv32_obi_pkg.sv
// Shared types for the picorv32-to-OBI bridge: FSM states, channel select and
// the default read data handed back to the core on a failed access.
package picorv32_obi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    CH_INSTR = 1'b0,
    CH_DATA  = 1'b1
  } channel_e;

  // EBREAK, so a core that consumes a failed fetch traps instead of running junk.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0010_0073;

  // A store can never be an instruction fetch.
  function automatic logic is_illegal(input logic instr, input logic [3:0] wstrb);
    return instr && (wstrb != 4'b0000);
  endfunction

endpackage

// File: rtl/picorv32_obi_bridge.sv
// Registered bridge from the picorv32 native memory port to OBI instr/data masters,
// with one outstanding access, response timeout, sticky bus-error capture.
module picorv32_obi_bridge
  import picorv32_obi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          UNIFIED        = 1'b0,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid_i,
  input  logic        cpu_instr_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wstrb_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_reg;
  channel_e         ch_reg;
  logic [31:0]      addr_reg;
  logic [1:0]       orphan_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;

  channel_e    new_ch;
  logic        new_illegal;
  logic        act_gnt;
  logic        act_rvalid;
  logic        act_err;
  logic [31:0] act_rdata;
  logic        is_write;
  logic        tmo_hit;
  logic        err_event;
  logic [31:0] err_at;

  assign new_ch      = (UNIFIED || !cpu_instr_i) ? CH_DATA : CH_INSTR;
  assign new_illegal = is_illegal(cpu_instr_i, cpu_wstrb_i);
  assign act_gnt     = (ch_reg == CH_DATA) ? data_gnt_i : instr_gnt_i;
  assign act_rvalid  = ((ch_reg == CH_DATA) ? data_rvalid_i : instr_rvalid_i) && !orphan_reg[ch_reg];
  assign act_err     = (ch_reg == CH_DATA) ? data_err_i : instr_err_i;
  assign act_rdata   = (ch_reg == CH_DATA) ? data_rdata_i : instr_rdata_i;
  assign is_write    = (ch_reg == CH_DATA) && data_we_o;
  // Fires on the last permitted RSP cycle so DONE follows exactly TIMEOUT_CYCLES RSP cycles.
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && ((tmo_cnt_reg + CNT_W'(1)) == CNT_LAST);

  always_comb begin
    err_event = 1'b0;
    err_at    = addr_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_valid_i && new_illegal) begin
          err_event = 1'b1;
          err_at    = cpu_addr_i;
        end
      end
      RSP: begin
        if (act_rvalid) err_event = act_err;
        else if (tmo_hit) err_event = 1'b1;
      end
      default: err_event = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ch_reg       <= CH_INSTR;
      addr_reg     <= '0;
      orphan_reg   <= '0;
      tmo_cnt_reg  <= '0;
      cpu_ready_o  <= 1'b0;
      cpu_rdata_o  <= '0;
      instr_req_o  <= 1'b0;
      instr_addr_o <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      bus_err_o    <= 1'b0;
      err_addr_o   <= '0;
    end else begin
      cpu_ready_o <= 1'b0;

      // A response that belongs to a timed-out access is swallowed wherever it lands.
      if (orphan_reg[CH_INSTR] && instr_rvalid_i) orphan_reg[CH_INSTR] <= 1'b0;
      if (orphan_reg[CH_DATA] && data_rvalid_i) orphan_reg[CH_DATA] <= 1'b0;

      if (err_event) begin
        if (!bus_err_o) err_addr_o <= err_at;
        bus_err_o <= 1'b1;
      end else if (err_clr_i) begin
        bus_err_o <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (cpu_valid_i) begin
            if (new_illegal) begin
              addr_reg    <= cpu_addr_i;
              ch_reg      <= new_ch;
              cpu_ready_o <= 1'b1;
              cpu_rdata_o <= ERR_RDATA;
              state_reg   <= DONE;
            end else if (!orphan_reg[new_ch]) begin
              addr_reg  <= cpu_addr_i;
              ch_reg    <= new_ch;
              state_reg <= REQ;
              if (new_ch == CH_DATA) begin
                data_req_o   <= 1'b1;
                data_addr_o  <= cpu_addr_i;
                data_we_o    <= |cpu_wstrb_i;
                data_be_o    <= cpu_wstrb_i;
                data_wdata_o <= cpu_wdata_i;
                instr_req_o  <= 1'b0;
                instr_addr_o <= '0;
              end else begin
                instr_req_o  <= 1'b1;
                instr_addr_o <= cpu_addr_i;
                data_req_o   <= 1'b0;
                data_addr_o  <= '0;
                data_we_o    <= 1'b0;
                data_be_o    <= '0;
                data_wdata_o <= '0;
              end
            end
          end
        end
        REQ: begin
          if (act_gnt) begin
            instr_req_o <= 1'b0;
            data_req_o  <= 1'b0;
            tmo_cnt_reg <= '0;
            state_reg   <= RSP;
          end
        end
        RSP: begin
          if (act_rvalid) begin
            cpu_ready_o <= 1'b1;
            cpu_rdata_o <= act_err ? ERR_RDATA : (is_write ? 32'h0 : act_rdata);
            state_reg   <= DONE;
          end else if (tmo_hit) begin
            cpu_ready_o        <= 1'b1;
            cpu_rdata_o        <= ERR_RDATA;
            orphan_reg[ch_reg] <= 1'b1;
            state_reg          <= DONE;
          end else if (tmo_cnt_reg != CNT_LAST) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
